alu_nbit_seq: RTL and testbench

Parametrised, registered N-bit successor to the 1-bit ALU. It supports the same six operations (ADD, SUB, MUL, AND, OR, XOR) on WIDTH-bit operands, with a Start/Done handshake. MUL is a WIDTH-cycle shift-add multiplier; all other ops complete in one cycle. Outputs carry, signed-overflow, zero and illegal-op flags, all registered. It is the datapath execution unit that the team's upcoming controller issues operations to.

---
 rtl/alu_nbit_seq.sv | 164 ++++++++++++++++
 tb/tb_alu_nbit_seq.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_nbit_seq.sv
// alu_nbit_seq: registered WIDTH-bit ALU with a Start/Done handshake.
// ADD, SUB, AND, OR, XOR and illegal opcodes complete in one cycle; MUL is a
// WIDTH-cycle shift-add multiplier. Result and all flags are registered and
// held until the next completion.
//
// Handshake: a request is accepted at a rising edge where Start=1 and Busy=0
// (this includes the Done cycle, so issue can be back-to-back). A, B and Op are
// captured only at that edge. Start while Busy=1 is dropped, not queued. Done
// is a one-cycle pulse; Result and flags are valid from the Done cycle onward.
module alu_nbit_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [2:0]           Op,
  output logic                 Busy,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   Result,
  output logic                 CarryOut,
  output logic                 Overflow,
  output logic                 Zero,
  output logic                 Error,
  output logic [1:0]           state_dbg
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MULT   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state, state_nx;

  // Multiplier state: bit RW of p holds the carry out of the upper-half add.
  logic [RW:0]        p;
  logic [WIDTH-1:0]   mcand;
  logic [CW-1:0]      cnt;

  logic               accept;
  logic               mul_last;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_diff;
  logic [WIDTH:0]     mul_sum;
  logic [RW:0]        p_add;
  logic [RW:0]        p_shift;

  logic [RW-1:0]      op_res;
  logic               op_c;
  logic               op_v;
  logic               op_err;

  assign accept   = Start && (state != MULT);
  assign mul_last = (cnt == CW'(WIDTH - 1));
  assign add_sum  = {1'b0, A} + {1'b0, B};
  // SUB as A + ~B + 1 so the top bit is the no-borrow (A >= B) indication.
  assign sub_diff = {1'b0, A} + {1'b0, ~B} + (WIDTH + 1)'(1);
  assign mul_sum  = {1'b0, p[RW-1:WIDTH]} + {1'b0, mcand};
  assign p_add    = p[0] ? {mul_sum, p[WIDTH-1:0]} : p;
  assign p_shift  = {1'b0, p_add[RW:1]};
  assign state_dbg = state;

  // Single-cycle operation results and flags from the live inputs.
  always_comb begin
    op_res = '0;
    op_c   = 1'b0;
    op_v   = 1'b0;
    op_err = 1'b0;
    case (Op)
      OP_ADD: begin
        op_res = {{WIDTH{1'b0}}, add_sum[WIDTH-1:0]};
        op_c   = add_sum[WIDTH];
        op_v   = (A[WIDTH-1] == B[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        op_res = {{WIDTH{1'b0}}, sub_diff[WIDTH-1:0]};
        op_c   = sub_diff[WIDTH];
        op_v   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_MUL: op_res = '0;
      OP_AND: op_res = {{WIDTH{1'b0}}, A & B};
      OP_OR:  op_res = {{WIDTH{1'b0}}, A | B};
      OP_XOR: op_res = {{WIDTH{1'b0}}, A ^ B};
      default: op_err = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic and Busy/Done decode.
  always_comb begin
    state_nx = state;
    Busy     = 1'b0;
    Done     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nx = (Op == OP_MUL) ? MULT : FINISH;
      end
      MULT: begin
        Busy = 1'b1;
        if (mul_last) state_nx = FINISH;
      end
      FINISH: begin
        Done = 1'b1;
        if (accept) state_nx = (Op == OP_MUL) ? MULT : FINISH;
        else        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand capture, multiplier iteration and result/flag write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      p        <= '0;
      mcand    <= '0;
      cnt      <= '0;
      Result   <= '0;
      CarryOut <= 1'b0;
      Overflow <= 1'b0;
      Zero     <= 1'b0;
      Error    <= 1'b0;
    end else if (accept) begin
      if (Op == OP_MUL) begin
        p     <= {1'b0, {WIDTH{1'b0}}, B};
        mcand <= A;
        cnt   <= '0;
      end else begin
        Result   <= op_res;
        CarryOut <= op_c;
        Overflow <= op_v;
        Zero     <= (op_res == '0);
        Error    <= op_err;
      end
    end else if (state == MULT) begin
      p   <= p_shift;
      cnt <= cnt + CW'(1);
      if (mul_last) begin
        Result   <= p_shift[RW-1:0];
        CarryOut <= (p_shift[RW-1:WIDTH] != '0);
        Overflow <= 1'b0;
        Zero     <= (p_shift[RW-1:0] == '0);
        Error    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_nbit_seq.sv
// tb_alu_nbit_seq: directed bench for alu_nbit_seq at WIDTH=8.
// Inputs change and outputs are sampled on the falling edge.
module tb_alu_nbit_seq;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           Start;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic [2:0]     Op;
  logic           Busy;
  logic           Done;
  logic [2*W-1:0] Result;
  logic           CarryOut;
  logic           Overflow;
  logic           Zero;
  logic           Error;
  logic [1:0]     state_dbg;

  int total = 0;
  int bad   = 0;

  // obs packs {Done, Busy, Error, Zero, Overflow, CarryOut, Result}.
  logic [21:0] obs;
  logic [21:0] exp_v;
  assign obs = {Done, Busy, Error, Zero, Overflow, CarryOut, Result};

  alu_nbit_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .Start(Start), .A(A), .B(B), .Op(Op),
    .Busy(Busy), .Done(Done), .Result(Result), .CarryOut(CarryOut),
    .Overflow(Overflow), .Zero(Zero), .Error(Error), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic s, input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    Start = s; Op = o; A = a; B = b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 3'b000, 8'hFF, 8'h01);
    tick(); tick(); tick();
    total++;
    if (obs !== 22'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h expected %h", obs, 22'h0);
    end
    total++;
    if (state_dbg !== 2'd0) begin
      bad++;
      $display("FAIL reset_state: got %0d expected 0", state_dbg);
    end
    rst = 1'b0;
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    tick();
  endtask

  task automatic test_add();
    drive(1'b1, 3'b000, 8'hFF, 8'h01);
    tick();
    Start = 1'b0;
    exp_v = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL add_ff_01: got %h expected %h", obs, exp_v);
    end
    tick();
    total++;
    if (Done !== 1'b0 || Result !== 16'h0000) begin
      bad++;
      $display("FAIL add_done_single: got done=%b res=%h expected done=0 res=0000", Done, Result);
    end
    drive(1'b1, 3'b000, 8'h7F, 8'h01);
    tick();
    Start = 1'b0;
    exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0080};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL add_7f_01: got %h expected %h", obs, exp_v);
    end
    tick();
  endtask

  task automatic test_sub();
    drive(1'b1, 3'b001, 8'h80, 8'h01);
    tick();
    Start = 1'b0;
    exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h007F};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL sub_80_01: got %h expected %h", obs, exp_v);
    end
    tick();
    drive(1'b1, 3'b001, 8'h00, 8'h01);
    tick();
    Start = 1'b0;
    exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00FF};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL sub_00_01: got %h expected %h", obs, exp_v);
    end
    tick();
  endtask

  task automatic test_mul();
    int busy_bad;
    int cnt;
    busy_bad = 0;
    drive(1'b1, 3'b010, 8'hFF, 8'hFF);
    tick();
    Start = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (Busy !== 1'b1 || Done !== 1'b0) busy_bad++;
      if (i == 3) drive(1'b1, 3'b000, 8'h01, 8'h02);
      if (i == 4) Start = 1'b0;
      tick();
    end
    total++;
    if (busy_bad !== 0) begin
      bad++;
      $display("FAIL mul_busy_window: got %0d bad cycles expected 0", busy_bad);
    end
    exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFE01};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL mul_ff_ff: got %h expected %h", obs, exp_v);
    end
    tick();
    exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFE01};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL mul_hold: got %h expected %h", obs, exp_v);
    end
    drive(1'b1, 3'b010, 8'h0F, 8'h00);
    tick();
    Start = 1'b0;
    cnt = 1;
    while (Done !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    total++;
    if (cnt !== W + 1) begin
      bad++;
      $display("FAIL mul_latency: got %0d expected %0d", cnt, W + 1);
    end
    exp_v = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL mul_0f_00: got %h expected %h", obs, exp_v);
    end
    tick();
  endtask

  task automatic test_mul_back_to_back();
    int cnt;
    drive(1'b1, 3'b010, 8'h03, 8'h05);
    tick();
    A = 8'h02; B = 8'h07;
    cnt = 1;
    while (Done !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    total++;
    if (cnt !== W + 1 || Result !== 16'h000F) begin
      bad++;
      $display("FAIL mul_b2b_first: got cnt=%0d res=%h expected cnt=%0d res=000f", cnt, Result, W + 1);
    end
    tick();
    Start = 1'b0;
    cnt = 1;
    while (Done !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    total++;
    if (cnt !== W + 1 || Result !== 16'h000E) begin
      bad++;
      $display("FAIL mul_b2b_second: got cnt=%0d res=%h expected cnt=%0d res=000e", cnt, Result, W + 1);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 3'b011, 8'hF0, 8'h3C);
    tick();
    total++;
    if (Done !== 1'b1 || Result !== 16'h0030) begin
      bad++;
      $display("FAIL b2b_and: got done=%b res=%h expected done=1 res=0030", Done, Result);
    end
    Op = 3'b100;
    tick();
    total++;
    if (Done !== 1'b1 || Result !== 16'h00FC) begin
      bad++;
      $display("FAIL b2b_or: got done=%b res=%h expected done=1 res=00fc", Done, Result);
    end
    Op = 3'b101;
    tick();
    Start = 1'b0;
    total++;
    if (Done !== 1'b1 || Result !== 16'h00CC || CarryOut !== 1'b0 || Overflow !== 1'b0) begin
      bad++;
      $display("FAIL b2b_xor: got done=%b res=%h c=%b v=%b expected done=1 res=00cc c=0 v=0",
               Done, Result, CarryOut, Overflow);
    end
    tick();
    total++;
    if (Done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_done_drop: got %b expected 0", Done);
    end
  endtask

  task automatic test_reset_mid_mul();
    int dones;
    drive(1'b1, 3'b010, 8'hFF, 8'hFF);
    tick();
    Start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Result !== 16'h0000 || state_dbg !== 2'd0) begin
      bad++;
      $display("FAIL rst_mid_mul: got busy=%b done=%b res=%h st=%0d expected 0 0 0000 0",
               Busy, Done, Result, state_dbg);
    end
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (Done === 1'b1) dones++;
      tick();
    end
    total++;
    if (dones !== 0) begin
      bad++;
      $display("FAIL rst_no_done: got %0d expected 0", dones);
    end
    drive(1'b1, 3'b000, 8'h02, 8'h03);
    tick();
    Start = 1'b0;
    exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0005};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL rst_then_add: got %h expected %h", obs, exp_v);
    end
    tick();
  endtask

  task automatic test_illegal();
    drive(1'b1, 3'b110, 8'h55, 8'h0F);
    tick();
    Start = 1'b0;
    exp_v = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL illegal_110: got %h expected %h", obs, exp_v);
    end
    tick();
    drive(1'b1, 3'b101, 8'h55, 8'h55);
    tick();
    Start = 1'b0;
    exp_v = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL xor_clears_err: got %h expected %h", obs, exp_v);
    end
    tick();
    drive(1'b1, 3'b111, 8'hFF, 8'hFF);
    tick();
    Start = 1'b0;
    exp_v = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL illegal_111: got %h expected %h", obs, exp_v);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_mul_back_to_back();
    test_back_to_back();
    test_reset_mid_mul();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
